// File: rtl/gpio_in_filter_pkg.sv
// Shared defaults and the per-channel debounce state encoding for gpio_in_filter.
package gpio_in_filter_pkg;

    localparam int unsigned NUM_CH_DEFAULT    = 32;
    localparam int unsigned CNT_WIDTH_DEFAULT = 8;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } ch_state_e;

endpackage : gpio_in_filter_pkg

// File: rtl/gpio_in_filter_ch.sv
// One GPIO input channel: 2-flop synchroniser, debounce FSM with saturating counter,
// and registered edge pulses when GPIO_IN_FILTER_EDGE_EN is defined.
module gpio_in_filter_ch
    import gpio_in_filter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pad_i,
    input  logic [CNT_WIDTH-1:0] debounce_len_i,
    input  logic                 bypass_i,
    input  logic                 edge_en_i,
    output logic                 filt_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [1:0]           sync_q;
    logic                 sync;
    logic                 filt_q, filt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_m1;
    ch_state_e            state_q, state_d;

    assign sync   = sync_q[1];
    assign len_m1 = (debounce_len_i == '0) ? '0 : debounce_len_i - CNT_WIDTH'(1);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= STABLE;
        end else begin
            sync_q  <= {sync_q[0], pad_i};
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (bypass_i) begin
            filt_d  = sync;
            cnt_d   = '0;
            state_d = STABLE;
        end else begin
            unique case (state_q)
                STABLE: begin
                    if (sync != filt_q) begin
                        if (len_m1 == '0) begin
                            filt_d = sync;
                        end else begin
                            cnt_d   = CNT_WIDTH'(1);
                            state_d = SETTLING;
                        end
                    end
                end
                SETTLING: begin
                    if (sync == filt_q) begin
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q >= len_m1) begin
                        // >= lets a shortened length commit on the very next cycle
                        filt_d  = sync;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_d = STABLE;
            endcase
        end
    end

    assign filt_o = filt_q;

`ifdef GPIO_IN_FILTER_EDGE_EN
    logic filt_prev_q, rise_q, fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            filt_prev_q <= filt_q;
            rise_q      <= edge_en_i &  filt_q & ~filt_prev_q;
            fall_q      <= edge_en_i & ~filt_q &  filt_prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    logic unused_edge_en;
    assign unused_edge_en = edge_en_i;
    assign rise_o         = 1'b0;
    assign fall_o         = 1'b0;
`endif

endmodule : gpio_in_filter_ch

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: NUM_CH debounced channels plus a registered event output.
// Edge pulses and event_o exist only when GPIO_IN_FILTER_EDGE_EN is defined.
module gpio_in_filter
    import gpio_in_filter_pkg::*;
#(
    parameter int unsigned NUM_CH    = NUM_CH_DEFAULT,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    gpio_pad_i,
    input  logic [CNT_WIDTH-1:0] debounce_len_i,
    input  logic [NUM_CH-1:0]    bypass_i,
    input  logic [NUM_CH-1:0]    edge_en_i,
    output logic [NUM_CH-1:0]    gpio_in_o,
    output logic [NUM_CH-1:0]    rise_o,
    output logic [NUM_CH-1:0]    fall_o,
    output logic                 event_o
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gpio_in_filter_ch #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .pad_i          (gpio_pad_i[i]),
            .debounce_len_i (debounce_len_i),
            .bypass_i       (bypass_i[i]),
            .edge_en_i      (edge_en_i[i]),
            .filt_o         (gpio_in_o[i]),
            .rise_o         (rise_o[i]),
            .fall_o         (fall_o[i])
        );
    end

`ifdef GPIO_IN_FILTER_EDGE_EN
    logic event_q;

    // One pulse per cycle however many channels produced an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_q <= 1'b0;
        end else begin
            event_q <= |(rise_o | fall_o);
        end
    end

    assign event_o = event_q;
`else
    assign event_o = 1'b0;
`endif

endmodule : gpio_in_filter

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter; expectations are queued when stimulus is driven
// and compared when their cycle comes round.
module tb_gpio_in_filter;

    localparam int NUM_CH = 32;
    localparam int CW     = 8;
`ifdef GPIO_IN_FILTER_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] gpio_pad_i;
    logic [CW-1:0]     debounce_len_i;
    logic [NUM_CH-1:0] bypass_i;
    logic [NUM_CH-1:0] edge_en_i;
    logic [NUM_CH-1:0] gpio_in_o;
    logic [NUM_CH-1:0] rise_o;
    logic [NUM_CH-1:0] fall_o;
    logic              event_o;

    gpio_in_filter #(
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_pad_i     (gpio_pad_i),
        .debounce_len_i (debounce_len_i),
        .bypass_i       (bypass_i),
        .edge_en_i      (edge_en_i),
        .gpio_in_o      (gpio_in_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .event_o        (event_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {K_GPIO_BIT, K_RISE, K_FALL, K_EVENT, K_GPIO_VEC} kind_e;
    typedef struct {
        string       tag;
        int          at;
        kind_e       kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int dly, input kind_e kind,
                             input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.at   = cyc + dly;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_e kind, input int idx);
        case (kind)
            K_GPIO_BIT: return {31'b0, gpio_in_o[idx]};
            K_RISE:     return {31'b0, rise_o[idx]};
            K_FALL:     return {31'b0, fall_o[idx]};
            K_EVENT:    return {31'b0, event_o};
            default:    return gpio_in_o;
        endcase
    endfunction

    // Outputs are sampled 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].tag, observe(sb[i].kind, sb[i].idx), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        gpio_pad_i     = '1;
        debounce_len_i = 8'd4;
        bypass_i       = '0;
        edge_en_i      = 32'h8000_0009;
        step(4);
        check("rst_gpio",  gpio_in_o, 32'h0);
        check("rst_rise",  rise_o,    32'h0);
        check("rst_fall",  fall_o,    32'h0);
        check("rst_event", {31'b0, event_o}, 32'h0);
        gpio_pad_i = '0;
        step(1);
        rst = 1'b0;
        step(3);

        // len=4 rise on ch0, then fall
        gpio_pad_i[0] = 1'b1;
        expect_at("t1_gpio0_at5", 5, K_GPIO_BIT, 0, 0);
        expect_at("t1_gpio0_at6", 6, K_GPIO_BIT, 0, 1);
        expect_at("t1_rise0_at6", 6, K_RISE, 0, 0);
        expect_at("t1_rise0_at7", 7, K_RISE, 0, {31'b0, EDGE});
        expect_at("t1_rise0_at8", 8, K_RISE, 0, 0);
        expect_at("t1_fall0_at7", 7, K_FALL, 0, 0);
        expect_at("t1_evt_at7",   7, K_EVENT, 0, 0);
        expect_at("t1_evt_at8",   8, K_EVENT, 0, {31'b0, EDGE});
        expect_at("t1_evt_at9",   9, K_EVENT, 0, 0);
        drain();
        gpio_pad_i[0] = 1'b0;
        expect_at("t1f_gpio0_at5", 5, K_GPIO_BIT, 0, 1);
        expect_at("t1f_gpio0_at6", 6, K_GPIO_BIT, 0, 0);
        expect_at("t1f_fall0_at7", 7, K_FALL, 0, {31'b0, EDGE});
        expect_at("t1f_fall0_at8", 8, K_FALL, 0, 0);
        expect_at("t1f_rise0_at7", 7, K_RISE, 0, 0);
        expect_at("t1f_evt_at8",   8, K_EVENT, 0, {31'b0, EDGE});
        expect_at("t1f_evt_at9",   9, K_EVENT, 0, 0);
        drain();

        // 3-cycle glitch on ch3 is rejected
        gpio_pad_i[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            expect_at("t2_gpio3", k, K_GPIO_BIT, 3, 0);
            expect_at("t2_rise3", k, K_RISE, 3, 0);
            expect_at("t2_fall3", k, K_FALL, 3, 0);
            expect_at("t2_event", k, K_EVENT, 0, 0);
        end
        step(3);
        gpio_pad_i[3] = 1'b0;
        drain();

        // len=200 lowered to 5 once cnt reaches 50
        debounce_len_i = 8'd200;
        gpio_pad_i[1]  = 1'b1;
        expect_at("t3_gpio1_at51", 51, K_GPIO_BIT, 1, 0);
        expect_at("t3_gpio1_at52", 52, K_GPIO_BIT, 1, 0);
        expect_at("t3_gpio1_at53", 53, K_GPIO_BIT, 1, 1);
        step(52);
        debounce_len_i = 8'd5;
        drain();

        // len=0 behaves as len=1
        debounce_len_i = 8'd0;
        gpio_pad_i[2]  = 1'b1;
        expect_at("t3z_gpio2_at2", 2, K_GPIO_BIT, 2, 0);
        expect_at("t3z_gpio2_at3", 3, K_GPIO_BIT, 2, 1);
        drain();

        // bypass on ch7: pad toggling every cycle appears 3 cycles later
        debounce_len_i = 8'd4;
        bypass_i[7]    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            gpio_pad_i[7] = ~k[0];
            expect_at("t4_bypass_gpio7", 3, K_GPIO_BIT, 7, {31'b0, ~k[0]});
            step(1);
        end
        drain();
        bypass_i[7] = 1'b0;
        step(1);
        gpio_pad_i[7] = 1'b1;
        expect_at("t4_after_gpio7_at5", 5, K_GPIO_BIT, 7, 0);
        expect_at("t4_after_gpio7_at6", 6, K_GPIO_BIT, 7, 1);
        drain();

        // reset while ch4 is settling at cnt=3 of len=8
        debounce_len_i = 8'd8;
        gpio_pad_i[4]  = 1'b1;
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_gpio",  gpio_in_o, 32'h0);
        check("t5_rst_rise",  rise_o,    32'h0);
        check("t5_rst_fall",  fall_o,    32'h0);
        check("t5_rst_event", {31'b0, event_o}, 32'h0);
        step(2);
        rst = 1'b0;
        expect_at("t5_gpio_at9",  9,  K_GPIO_VEC, 0, 32'h0000_0000);
        expect_at("t5_gpio_at10", 10, K_GPIO_VEC, 0, 32'h0000_0096);
        drain();

        // simultaneous rise on ch0 and ch31
        debounce_len_i = 8'd4;
        edge_en_i      = 32'h8000_0001;
        gpio_pad_i[0]  = 1'b1;
        gpio_pad_i[31] = 1'b1;
        expect_at("t6_gpio_at6",   6, K_GPIO_VEC, 0, 32'h8000_0097);
        expect_at("t6_rise0_at7",  7, K_RISE, 0,  {31'b0, EDGE});
        expect_at("t6_rise31_at7", 7, K_RISE, 31, {31'b0, EDGE});
        expect_at("t6_rise31_at8", 8, K_RISE, 31, 0);
        expect_at("t6_evt_at7",    7, K_EVENT, 0, 0);
        expect_at("t6_evt_at8",    8, K_EVENT, 0, {31'b0, EDGE});
        expect_at("t6_evt_at9",    9, K_EVENT, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gpio_in_filter

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 32, the number of GPIO input channels.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, the width of the debounce counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port gpio_pad_i, input, NUM_CH bits: raw asynchronous pad inputs.
REQ-006 The block SHALL have port debounce_len_i, input, CNT_WIDTH bits: required stable cycles before a change is accepted.
REQ-007 The block SHALL have port bypass_i, input, NUM_CH bits: per channel, 1 = synchronise only, no debounce.
REQ-008 The block SHALL have port edge_en_i, input, NUM_CH bits: per-channel edge event enable.
REQ-009 The block SHALL have port gpio_in_o, output, NUM_CH bits: filtered value; drives the peripherals gpio_in input.
REQ-010 The block SHALL have ports rise_o and fall_o, outputs, NUM_CH bits each: single-cycle edge pulses.
REQ-011 The block SHALL have port event_o, output, 1 bit: OR of all enabled edges; feeds the event unit.

Function
REQ-012 Each channel SHALL pass gpio_pad_i through a 2-flop synchroniser; the second flop is sync[i].
REQ-013 Each channel SHALL use two states: STABLE (sync == filt) and SETTLING (sync != filt).
REQ-014 In SETTLING, cnt SHALL increment by 1 per cycle.
REQ-015 When cnt >= debounce_len_i-1 in SETTLING, filt SHALL take sync, cnt SHALL clear, and state SHALL return to STABLE.
REQ-016 If sync returns to filt during SETTLING, cnt SHALL clear and state SHALL return to STABLE, with filt unchanged (glitch rejected).
REQ-017 debounce_len_i = 0 SHALL behave as 1.
REQ-018 The latency from a pad change to gpio_in_o SHALL be 2 + max(len,1) cycles.
REQ-019 cnt SHALL saturate at its all-ones value and never wrap.
REQ-020 If debounce_len_i is lowered mid-count, the >= compare in REQ-015 SHALL commit the change on the next SETTLING cycle.
REQ-021 With bypass_i[i] = 1, filt SHALL follow sync one cycle later and cnt SHALL be held at 0.
REQ-022 rise_o[i] / fall_o[i] SHALL pulse for exactly one cycle, in the cycle after filt[i] changes 0->1 / 1->0, gated by edge_en_i[i].
REQ-023 event_o SHALL be registered and asserted one cycle after any rise_o | fall_o bit is set.
REQ-024 Simultaneous edges on multiple channels SHALL produce one event_o pulse per cycle in which edges occur.
REQ-025 gpio_in_o SHALL equal the filt register directly, with no combinational path from gpio_pad_i.

Reset
REQ-026 While rst is high, sync, filt, cnt, rise_o, fall_o and event_o SHALL all be 0 and every channel SHALL be in STABLE.
REQ-027 Reset asserted mid-SETTLING SHALL abort the count immediately.
REQ-028 After reset release, a pad held at 1 SHALL reach gpio_in_o 2 + len cycles later.

Configuration
REQ-029 When GPIO_IN_FILTER_EDGE_EN is defined, the edge-detect logic SHALL be built per REQ-022 to REQ-024.
REQ-030 When GPIO_IN_FILTER_EDGE_EN is undefined, no edge registers SHALL be built, rise_o, fall_o and event_o SHALL be tied to 0, and edge_en_i SHALL be ignored.

Structure
REQ-031 Package gpio_in_filter_pkg SHALL hold the NUM_CH and CNT_WIDTH defaults and the state enum (STABLE, SETTLING).
REQ-032 Sub-module gpio_in_filter_ch SHALL implement one channel (sync, FSM, counter, edge detect); the top SHALL instantiate it NUM_CH times in a generate loop and OR the event terms.

Verification
REQ-033 len=4, ch0 pad 0->1 held: gpio_in_o[0] rises exactly 6 cycles after the pad change, rise_o[0] and event_o each pulse once.
REQ-034 len=4, ch3 pad 3-cycle high glitch: gpio_in_o[3] stays 0, no rise_o/fall_o/event_o pulse.
REQ-035 len=200 then lowered to 5 at cnt=50: commit on the next cycle; len=0: behaves as len=1 (latency 3).
REQ-036 bypass_i[7]=1, pad toggling every cycle: gpio_in_o[7] tracks the pad delayed by 3 cycles, cnt held at 0.
REQ-037 rst asserted at cnt=3 of len=8: all outputs 0 immediately; after release, a held pad=1 gives gpio_in_o after 10 cycles.
REQ-038 Channels 0 and 31 rising in the same cycle with edge_en_i=0x8000_0001: both rise_o bits pulse, one event_o pulse; macro undefined: event_o constantly 0.
